// File: rtl/multicycle_core.sv
// rtl/multicycle_core.sv - multi-cycle core with one shared req/ack memory port
// Define STACK_OPS_EN to add the sp register and PUSH/POP/CALL/RET.
module multicycle_core #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5,
   parameter int ADDR_W = 16,
`ifdef STACK_OPS_EN
   parameter logic [ADDR_W-1:0] STACK_TOP = 16'hFFFF,
`endif
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              reset,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic              halted,
   output logic [ADDR_W-1:0] pc_out
);

   typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

   state_t            state;
   logic [31:0]       ir;
   logic [ADDR_W-1:0] pc;
   logic [DATA_W-1:0] regs [2**REG_AW];
   logic [DATA_W-1:0] a, b, imm, res;
`ifdef STACK_OPS_EN
   logic [ADDR_W-1:0] sp;
`endif

   logic [5:0]        op, funct;
   logic [REG_AW-1:0] rs, rt, rd, dest;
   logic [DATA_W-1:0] alu_y, sum;
   logic [ADDR_W-1:0] jmp_pc;
   logic              taken, is_load, runs;

   assign op     = ir[31:26];
   assign funct  = ir[5:0];
   assign rs     = ir[21 +: REG_AW];
   assign rt     = ir[16 +: REG_AW];
   assign rd     = ir[11 +: REG_AW];
   assign pc_out = pc;

   always_comb begin
      sum = a + imm;
      case (funct)
         6'h20:   alu_y = a + b;
         6'h22:   alu_y = a - b;
         6'h24:   alu_y = a & b;
         6'h25:   alu_y = a | b;
         6'h26:   alu_y = a ^ b;
         6'h2A:   alu_y = DATA_W'($signed(a) < $signed(b));
         default: alu_y = '0;
      endcase
      // pc has already advanced past the branch, so the offset is relative to pc+1
      taken  = (a == b) ^ (op == 6'h05);
      jmp_pc = ADDR_W'(ir[25:0]);
      if (op == 6'h04 || op == 6'h05)
         jmp_pc = taken ? pc + ADDR_W'($signed(imm)) : pc;
      dest    = (op == 6'h00) ? rd : rt;
      is_load = (op == 6'h23);
      case (op)
         6'h00:   runs = funct inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h2A};
         6'h02, 6'h04, 6'h05, 6'h08, 6'h23, 6'h2B: runs = 1'b1;
`ifdef STACK_OPS_EN
         6'h30, 6'h31, 6'h32, 6'h33: runs = 1'b1;
`endif
         default: runs = 1'b0;
      endcase
`ifdef STACK_OPS_EN
      is_load = is_load || (op == 6'h31);
`endif
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= S_FETCH;
         pc        <= RESET_PC;
         ir        <= '0;
         a         <= '0;
         b         <= '0;
         imm       <= '0;
         res       <= '0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         halted    <= 1'b0;
         for (int i = 0; i < 2**REG_AW; i++) regs[i] <= '0;
`ifdef STACK_OPS_EN
         sp        <= STACK_TOP;
`endif
      end else begin
         case (state)
            S_FETCH: begin
               if (!mem_req) begin
                  mem_req  <= 1'b1;
                  mem_we   <= 1'b0;
                  mem_addr <= pc;
               end else if (mem_ack) begin
                  ir      <= 32'(mem_rdata);
                  pc      <= pc + ADDR_W'(1);
                  mem_req <= 1'b0;
                  state   <= S_DECODE;
               end
            end
            S_DECODE: begin
               a   <= regs[rs];
               b   <= regs[rt];
               imm <= DATA_W'($signed(ir[15:0]));
               if (runs) begin
                  state <= S_EXEC;
               end else begin
                  halted <= 1'b1;
                  state  <= S_HALT;
               end
            end
            S_EXEC: begin
               case (op)
                  6'h00: begin res <= alu_y; state <= S_WB; end
                  6'h08: begin res <= sum;   state <= S_WB; end
                  6'h23, 6'h2B: begin
                     mem_req   <= 1'b1;
                     mem_we    <= (op == 6'h2B);
                     mem_addr  <= ADDR_W'(sum);
                     mem_wdata <= b;
                     state     <= S_MEM;
                  end
                  6'h02, 6'h04, 6'h05: begin
                     pc       <= jmp_pc;
                     mem_req  <= 1'b1;
                     mem_we   <= 1'b0;
                     mem_addr <= jmp_pc;
                     state    <= S_FETCH;
                  end
`ifdef STACK_OPS_EN
                  6'h30, 6'h32: begin
                     sp        <= sp - ADDR_W'(1);
                     mem_req   <= 1'b1;
                     mem_we    <= 1'b1;
                     mem_addr  <= sp - ADDR_W'(1);
                     mem_wdata <= (op == 6'h30) ? b : DATA_W'(pc);
                     if (op == 6'h32) pc <= ADDR_W'(ir[25:0]);
                     state     <= S_MEM;
                  end
                  6'h31, 6'h33: begin
                     sp       <= sp + ADDR_W'(1);
                     mem_req  <= 1'b1;
                     mem_we   <= 1'b0;
                     mem_addr <= sp;
                     state    <= S_MEM;
                  end
`endif
                  default: begin halted <= 1'b1; state <= S_HALT; end
               endcase
            end
            S_MEM: begin
               if (mem_ack) begin
                  mem_we <= 1'b0;
                  if (is_load) begin
                     res     <= mem_rdata;
                     mem_req <= 1'b0;
                     state   <= S_WB;
`ifdef STACK_OPS_EN
                  end else if (op == 6'h33) begin
                     pc       <= ADDR_W'(mem_rdata);
                     mem_addr <= ADDR_W'(mem_rdata);
                     state    <= S_FETCH;
`endif
                  end else begin
                     // stores chain straight into the next fetch without dropping mem_req
                     mem_addr <= pc;
                     state    <= S_FETCH;
                  end
               end
            end
            S_WB: begin
               if (dest != '0) regs[dest] <= res;
               mem_req  <= 1'b1;
               mem_we   <= 1'b0;
               mem_addr <= pc;
               state    <= S_FETCH;
            end
            default: state <= S_HALT;
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_core.sv
// tb/tb_multicycle_core.sv - self-checking bench for multicycle_core
module tb_multicycle_core;
   localparam logic [31:0] HALT_I = 32'hFC00_0000;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        mem_req, mem_we, mem_ack, halted;
   logic [15:0] mem_addr, pc_out;
   logic [31:0] mem_wdata, mem_rdata;

   multicycle_core dut (
      .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .mem_ack(mem_ack), .halted(halted), .pc_out(pc_out)
   );

   always #5 clk = ~clk;

   logic [31:0] mem [65536];
   logic [31:0] mm  [65536];
   int checks = 0;
   int errors = 0;
   int wait_cyc = 0;
   bit rand_wait = 1'b0;
   int cyc = 0;
   int          log_cyc[$];
   logic [15:0] log_addr[$];
   bit          log_we[$];
   logic [31:0] log_data[$];

   typedef struct {
      logic [5:0]  funct;
      logic [31:0] a, b, exp;
   } vec_t;
   vec_t vt [9];

   function automatic logic [31:0] itype(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
      return {op, 5'(rs), 5'(rt), imm};
   endfunction

   function automatic logic [31:0] rtype(input logic [5:0] funct, input int rd, input int rs, input int rt);
      return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, funct};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 65536; i++) mem[i] = '0;
   endtask

   // Memory responder: configurable wait states, protocol-stability watch, transaction log.
   initial begin
      int cnt, need;
      bit pend;
      logic [15:0] p_addr;
      logic        p_we;
      logic [31:0] p_wdata;
      mem_ack = 1'b0; mem_rdata = '0; cnt = 0; need = 0; pend = 1'b0;
      p_addr = '0; p_we = 1'b0; p_wdata = '0;
      forever begin
         @(negedge clk);
         cyc++;
         mem_ack = 1'b0;
         if (pend && !reset) begin
            checks++;
            if (!mem_req || mem_addr !== p_addr || mem_we !== p_we || mem_wdata !== p_wdata) begin
               errors++;
               $display("FAIL req_stable: req=%0b addr=%h we=%0b wdata=%h, required req=1 addr=%h we=%0b wdata=%h",
                        mem_req, mem_addr, mem_we, mem_wdata, p_addr, p_we, p_wdata);
            end
         end
         if (!reset && mem_req === 1'b1) begin
            if (!pend) begin
               need = rand_wait ? int'($urandom_range(0, 2)) : wait_cyc;
               cnt = 0;
               pend = 1'b1;
               p_addr = mem_addr; p_we = mem_we; p_wdata = mem_wdata;
            end
            if (cnt == need) begin
               mem_ack = 1'b1;
               if (mem_we) mem[mem_addr] = mem_wdata;
               else mem_rdata = mem[mem_addr];
               log_cyc.push_back(cyc);
               log_addr.push_back(mem_addr);
               log_we.push_back(mem_we);
               log_data.push_back(mem_we ? mem_wdata : mem[mem_addr]);
               pend = 1'b0;
            end else begin
               cnt++;
            end
         end else begin
            pend = 1'b0;
         end
      end
   end

   // ISA-level reference interpreter over mm[]
   task automatic model_run();
      logic [31:0] r [32];
      logic [31:0] ins, x, y, se, v;
      int pc = 0;
      int steps = 0;
      bit run = 1'b1;
      for (int i = 0; i < 32; i++) r[i] = '0;
      while (run && steps < 2000) begin
         steps++;
         ins = mm[pc];
         pc = (pc + 1) % 65536;
         x = r[ins[25:21]];
         y = r[ins[20:16]];
         se = {{16{ins[15]}}, ins[15:0]};
         v = '0;
         case (ins[31:26])
            6'h00: begin
               case (ins[5:0])
                  6'h20: v = x + y;
                  6'h22: v = x - y;
                  6'h24: v = x & y;
                  6'h25: v = x | y;
                  6'h26: v = x ^ y;
                  6'h2A: v = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
                  default: run = 1'b0;
               endcase
               if (run && ins[15:11] != 5'd0) r[ins[15:11]] = v;
            end
            6'h08: if (ins[20:16] != 5'd0) r[ins[20:16]] = x + se;
            6'h23: if (ins[20:16] != 5'd0) r[ins[20:16]] = mm[(x + se) & 32'hFFFF];
            6'h2B: mm[(x + se) & 32'hFFFF] = y;
            6'h04: if (x == y) pc = (pc + int'(se)) & 32'hFFFF;
            6'h05: if (x != y) pc = (pc + int'(se)) & 32'hFFFF;
            6'h02: pc = int'(ins[15:0]);
            default: run = 1'b0;
         endcase
      end
   endtask

   task automatic run_dut(input string name, input int budget);
      int n = 0;
      reset = 1'b1;
      log_cyc.delete(); log_addr.delete(); log_we.delete(); log_data.delete();
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      while (halted !== 1'b1 && n < budget) begin
         @(negedge clk);
         n++;
      end
      check({name, "_halt"}, 32'(halted), 32'd1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int bad;
      vt[0] = '{6'h20, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001};
      vt[1] = '{6'h22, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE};
      vt[2] = '{6'h24, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0};
      vt[3] = '{6'h25, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFFF0_FFF0};
      vt[4] = '{6'h26, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF00_FF00};
      vt[5] = '{6'h2A, 32'h8000_0000, 32'h0000_0001, 32'h0000_0001};
      vt[6] = '{6'h2A, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000};
      vt[7] = '{6'h2A, 32'h0000_0003, 32'h0000_0003, 32'h0000_0000};
      vt[8] = '{6'h21, 32'h0000_0003, 32'h0000_0004, 32'hDEAD_BEEF};

      @(negedge clk);
      check("rst_req",   32'(mem_req),   32'd0);
      check("rst_we",    32'(mem_we),    32'd0);
      check("rst_addr",  32'(mem_addr),  32'd0);
      check("rst_wdata", mem_wdata,      32'd0);
      check("rst_halt",  32'(halted),    32'd0);
      check("rst_pc",    32'(pc_out),    32'd0);

      for (int i = 0; i < 9; i++) begin
         clear_mem();
         mem[0] = itype(6'h23, 0, 1, 16'h40);
         mem[1] = itype(6'h23, 0, 2, 16'h41);
         mem[2] = rtype(vt[i].funct, 3, 1, 2);
         mem[3] = itype(6'h2B, 0, 3, 16'h42);
         mem[4] = HALT_I;
         mem[16'h40] = vt[i].a;
         mem[16'h41] = vt[i].b;
         mem[16'h42] = 32'hDEAD_BEEF;
         run_dut("alu", 300);
         check($sformatf("alu_vec%0d", i), mem[16'h42], vt[i].exp);
      end

      clear_mem();
      mem[0] = itype(6'h08, 0, 1, 16'd5);
      mem[1] = itype(6'h08, 0, 2, 16'hFFFD);
      mem[2] = rtype(6'h20, 3, 1, 2);
      mem[3] = rtype(6'h2A, 4, 2, 1);
      mem[4] = itype(6'h2B, 0, 3, 16'd100);
      mem[5] = itype(6'h2B, 0, 4, 16'd101);
      mem[6] = HALT_I;
      run_dut("seq4", 300);
      check("seq4_r3", mem[100], 32'd2);
      check("seq4_r4", mem[101], 32'd1);
      check("seq4_cycles", 32'(log_cyc[4] - log_cyc[0]), 32'd16);

      wait_cyc = 3;
      clear_mem();
      mem[0] = itype(6'h08, 0, 1, 16'd5);
      mem[1] = itype(6'h2B, 0, 1, 16'd4);
      mem[2] = itype(6'h23, 0, 5, 16'd4);
      mem[3] = {6'h02, 26'd8};
      mem[8] = itype(6'h2B, 0, 5, 16'd200);
      mem[9] = HALT_I;
      run_dut("stall", 400);
      check("stall_r5", mem[200], 32'd5);
      check("stall_addi_cyc", 32'(log_cyc[1] - log_cyc[0]), 32'd7);
      check("stall_sw_cyc",   32'(log_cyc[3] - log_cyc[1]), 32'd10);
      check("stall_lw_cyc",   32'(log_cyc[5] - log_cyc[3]), 32'd11);
      wait_cyc = 0;

      clear_mem();
      for (int i = 0; i < 20; i++) mem[i] = HALT_I;
      mem[0]  = itype(6'h08, 0, 1, 16'd7);
      mem[1]  = {6'h02, 26'd10};
      mem[10] = itype(6'h04, 1, 1, 16'd2);
      mem[13] = itype(6'h05, 1, 1, 16'd2);
      run_dut("branch", 300);
      check("br_count", 32'(log_addr.size()), 32'd5);
      check("br_j_target", 32'(log_addr[2]), 32'd10);
      check("br_beq_taken", 32'(log_addr[3]), 32'd13);
      check("br_bne_fall", 32'(log_addr[4]), 32'd14);
      check("br_beq_cyc", 32'(log_cyc[3] - log_cyc[2]), 32'd3);

      clear_mem();
      mem[0] = itype(6'h08, 0, 1, 16'd5);
      mem[1] = rtype(6'h20, 0, 1, 1);
      mem[2] = itype(6'h2B, 0, 0, 16'd300);
      mem[3] = 32'hF800_0000;
      mem[4] = itype(6'h2B, 0, 1, 16'd301);
      mem[5] = HALT_I;
      mem[300] = 32'hDEAD_BEEF;
      mem[301] = 32'hDEAD_BEEF;
      run_dut("illegal", 300);
      check("r0_zero", mem[300], 32'd0);
      check("illegal_no_exec", mem[301], 32'hDEAD_BEEF);
      check("illegal_pc", 32'(pc_out), 32'd4);
      bad = 0;
      repeat (20) begin
         @(negedge clk);
         if (mem_req !== 1'b0 || halted !== 1'b1) bad++;
      end
      check("halt_quiet", 32'(bad), 32'd0);

      wait_cyc = 10;
      clear_mem();
      mem[0] = itype(6'h08, 0, 1, 16'd5);
      mem[1] = itype(6'h2B, 0, 1, 16'd50);
      mem[2] = HALT_I;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      bad = 0;
      while (mem_req !== 1'b1 && bad < 10) begin
         @(negedge clk);
         bad++;
      end
      check("midrst_req_seen", 32'(mem_req), 32'd1);
      repeat (3) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      check("midrst_req", 32'(mem_req), 32'd0);
      check("midrst_pc",  32'(pc_out),  32'd0);
      wait_cyc = 0;
      run_dut("restart", 300);
      check("restart_first", 32'(log_addr[0]), 32'd0);
      check("restart_r1", mem[50], 32'd5);

      rand_wait = 1'b1;
      for (int round = 0; round < 6; round++) begin
         int k;
         clear_mem();
         for (int i = 0; i < 6; i++) begin
            mem[i] = itype(6'h23, 0, i + 1, 16'h400 + 16'(i));
            mem[16'h400 + i] = $urandom;
         end
         for (int i = 6; i < 18; i++) begin
            k = int'($urandom_range(0, 6));
            case (k)
               0: mem[i] = rtype(6'h20, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
               1: mem[i] = rtype(6'h22, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
               2: mem[i] = rtype(6'h24, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
               3: mem[i] = rtype(6'h25, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
               4: mem[i] = rtype(6'h26, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
               5: mem[i] = rtype(6'h2A, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
               default: mem[i] = itype(6'h08, $urandom_range(0, 7), $urandom_range(0, 7), 16'($urandom));
            endcase
         end
         for (int i = 1; i < 8; i++) mem[17 + i] = itype(6'h2B, 0, i, 16'h500 + 16'(i));
         mem[25] = HALT_I;
         for (int i = 0; i < 65536; i++) mm[i] = mem[i];
         model_run();
         run_dut("rand", 2000);
         for (int i = 1; i < 8; i++)
            check($sformatf("rand%0d_r%0d", round, i), mem[16'h500 + i], mm[16'h500 + i]);
      end
      rand_wait = 1'b0;

`ifdef STACK_OPS_EN
      clear_mem();
      mem[0]      = {6'h02, 26'd7};
      mem[7]      = {6'h32, 26'h40};
      mem[16'h40] = {6'h33, 26'd0};
      mem[8]      = itype(6'h08, 0, 1, 16'd9);
      mem[9]      = itype(6'h30, 0, 1, 16'd0);
      mem[10]     = itype(6'h31, 0, 2, 16'd0);
      mem[11]     = itype(6'h2B, 0, 2, 16'h60);
      mem[12]     = HALT_I;
      run_dut("stack", 400);
      check("call_push_addr", 32'(log_addr[2]), 32'hFFFE);
      check("call_push_data", log_data[2], 32'd8);
      check("call_target", 32'(log_addr[3]), 32'h40);
      check("ret_target", 32'(log_addr[5]), 32'd8);
      check("push_after_ret", mem[16'hFFFE], 32'd9);
      check("pop_value", mem[16'h60], 32'd9);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
